// File: rtl/lcd1602_pkg.sv
// lcd1602_pkg
// Shared definitions for the LCD1602 single-digit display block:
//   - top-level and byte-writer FSM state encodings
//   - HD44780 command bytes used during init and addressing
//   - ASCII offsets for digit / dash rendering, plus small helpers
package lcd1602_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP    = 3'd0,
        ST_INIT     = 3'd1,
        ST_IDLE     = 3'd2,
        ST_SET_ADDR = 3'd3,
        ST_WR_CHAR  = 3'd4
    } disp_state_t;

    typedef enum logic [1:0] {
        BW_IDLE  = 2'd0,
        BW_SETUP = 2'd1,
        BW_EN    = 2'd2,
        BW_WAIT  = 2'd3
    } bw_state_t;

    localparam logic [7:0] CMD_FUNC_SET  = 8'h38; // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C; // display on, cursor off
    localparam logic [7:0] CMD_ENTRY     = 8'h06; // increment, no shift
    localparam logic [7:0] CMD_CLEAR     = 8'h01; // clear display (slow command)
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80; // OR with 7-bit DDRAM address

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_DASH = 8'h2D;

    localparam logic [1:0] INIT_LAST = 2'd3;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = CMD_FUNC_SET;
            2'd1:    cmd = CMD_DISP_ON;
            2'd2:    cmd = CMD_ENTRY;
            default: cmd = CMD_CLEAR;
        endcase
        return cmd;
    endfunction

    // Values above 9 have no glyph in this design and show as '-'.
    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? (ASCII_ZERO + {4'h0, d}) : ASCII_DASH;
    endfunction

endpackage

// File: rtl/lcd1602_byte_wr.sv
// lcd1602_byte_wr
// Issues one byte onto the LCD bus: one setup cycle with rs/data stable,
// EN_CYC cycles of lcd_en high, then a hold/wait period with en low.
// The wait is CLR_WAIT_CYC after the clear command, BYTE_WAIT_CYC otherwise.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_start         : request a byte; accepted only while o_idle is high
//   i_rs, i_data    : register-select and byte to send (latched on accept)
//   o_rs, o_data    : LCD bus, held from accept until the next accept
//   o_en            : LCD enable strobe
//   o_idle          : ready to accept i_start
//   o_done          : one-cycle pulse on the last cycle of the wait period
module lcd1602_byte_wr
    import lcd1602_pkg::*;
#(
    parameter int EN_CYC        = 25,
    parameter int BYTE_WAIT_CYC = 2_500,
    parameter int CLR_WAIT_CYC  = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    output logic       o_rs,
    output logic [7:0] o_data,
    output logic       o_en,
    output logic       o_idle,
    output logic       o_done
);

    localparam int MAX_CYC = (EN_CYC > BYTE_WAIT_CYC)
                           ? ((EN_CYC > CLR_WAIT_CYC) ? EN_CYC : CLR_WAIT_CYC)
                           : ((BYTE_WAIT_CYC > CLR_WAIT_CYC) ? BYTE_WAIT_CYC : CLR_WAIT_CYC);
    localparam int CW = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] EN_LAST   = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] BYTE_LAST = CW'(BYTE_WAIT_CYC - 1);
    localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_WAIT_CYC - 1);

    bw_state_t     r_state;
    bw_state_t     w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_wait_last;
    logic          r_rs;
    logic [7:0]    r_data;
    logic          r_en;
    logic          w_accept;

    assign w_accept = (r_state == BW_IDLE) && i_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= BW_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        o_done       = 1'b0;
        case (r_state)
            BW_IDLE:  if (i_start) w_state_next = BW_SETUP;
            BW_SETUP: w_state_next = BW_EN;
            BW_EN:    if (r_cnt == EN_LAST) w_state_next = BW_WAIT;
            BW_WAIT: begin
                if (r_cnt == r_wait_last) begin
                    w_state_next = BW_IDLE;
                    o_done       = 1'b1;
                end
            end
            default:  w_state_next = BW_IDLE;
        endcase
    end

    // Counter restarts from zero on every phase change, so it never needs
    // to saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        r_cnt <= '0;
        else if (w_state_next != r_state)  r_cnt <= '0;
        else if (r_state == BW_EN || r_state == BW_WAIT)
                                           r_cnt <= r_cnt + CW'(1);
    end

    // Bus registers are loaded on accept and held through the wait so the
    // LCD sees stable rs/data across the falling edge of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
            r_wait_last <= '0;
            r_en        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rs        <= i_rs;
                r_data      <= i_data;
                r_wait_last <= (!i_rs && i_data == CMD_CLEAR) ? CLR_LAST : BYTE_LAST;
            end
            r_en <= (w_state_next == BW_EN);
        end
    end

    assign o_rs   = r_rs;
    assign o_data = r_data;
    assign o_en   = r_en;
    assign o_idle = (r_state == BW_IDLE);

endmodule

// File: rtl/lcd1602_digit_disp.sv
// lcd1602_digit_disp
// Drives an HD44780-style LCD1602 in 8-bit write-only mode and keeps one
// character cell showing the current digit_in value ('0'-'9', '-' for 10-15).
// After reset: power-up wait, init command sequence, then the digit is
// rewritten whenever the synchronised input differs from what is shown.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   digit_in   : digit from the button stage (asynchronous, synchronised here)
//   lcd_rs     : 0 = command, 1 = data
//   lcd_rw     : always 0
//   lcd_en     : enable strobe
//   lcd_data   : 8-bit LCD bus
//   busy       : high whenever the controller is not in IDLE
module lcd1602_digit_disp
    import lcd1602_pkg::*;
#(
    parameter int         CLK_HZ        = 50_000_000,
    parameter int         PWRUP_CYC     = 1_000_000,
    parameter int         EN_CYC        = 25,
    parameter int         BYTE_WAIT_CYC = 2_500,
    parameter int         CLR_WAIT_CYC  = 100_000,
    parameter logic [6:0] DIGIT_ADDR    = 7'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit_in,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       busy
);

    // Timing parameters are given in cycles of CLK_HZ; a clock this slow
    // would make the default cycle counts meaningless.
    if (CLK_HZ < 1_000_000) begin : g_clk_chk
        $error("lcd1602_digit_disp: CLK_HZ too low for cycle-based timing");
    end

    localparam int PWR_W = $clog2(PWRUP_CYC + 1);
    localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(PWRUP_CYC - 1);

    disp_state_t      r_state;
    disp_state_t      w_state_next;
    logic [PWR_W-1:0] r_pwr_cnt;
    logic [1:0]       r_init_idx;
    logic             r_issued;
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_shown;

    logic             w_start;
    logic             w_rs;
    logic [7:0]       w_data;
    logic             w_bw_idle;
    logic             w_bw_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_PWRUP;
        else        r_state <= w_state_next;
    end

    // Each byte-sending state raises start once (r_issued blocks repeats)
    // and moves on when the byte writer reports done.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_rs         = 1'b0;
        w_data       = 8'h00;
        case (r_state)
            ST_PWRUP: begin
                if (r_pwr_cnt == PWR_LAST) w_state_next = ST_INIT;
            end
            ST_INIT: begin
                w_start = !r_issued;
                w_data  = init_cmd(r_init_idx);
                if (w_bw_done && r_init_idx == INIT_LAST) w_state_next = ST_SET_ADDR;
            end
            ST_IDLE: begin
                if (r_sync2 != r_shown) w_state_next = ST_SET_ADDR;
            end
            ST_SET_ADDR: begin
                w_start = !r_issued;
                w_data  = CMD_SET_DDRAM | {1'b0, DIGIT_ADDR};
                if (w_bw_done) w_state_next = ST_WR_CHAR;
            end
            ST_WR_CHAR: begin
                w_start = !r_issued;
                w_rs    = 1'b1;
                w_data  = digit_ascii(r_shown);
                if (w_bw_done) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_PWRUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwr_cnt  <= '0;
            r_init_idx <= 2'd0;
            r_issued   <= 1'b0;
            r_sync1    <= 4'h0;
            r_sync2    <= 4'h0;
            r_shown    <= 4'h0;
        end else begin
            r_sync1 <= digit_in;
            r_sync2 <= r_sync1;

            if (r_state == ST_PWRUP && w_state_next == ST_PWRUP)
                r_pwr_cnt <= r_pwr_cnt + PWR_W'(1);
            else
                r_pwr_cnt <= '0;

            if (r_state != ST_INIT)
                r_init_idx <= 2'd0;
            else if (w_bw_done)
                r_init_idx <= r_init_idx + 2'd1;

            if (w_bw_done)
                r_issued <= 1'b0;
            else if (w_start && w_bw_idle)
                r_issued <= 1'b1;

            // The digit is frozen at SET_ADDR entry; later input changes are
            // picked up by the IDLE compare once this update completes.
            if (w_state_next == ST_SET_ADDR && r_state != ST_SET_ADDR)
                r_shown <= r_sync2;
        end
    end

    lcd1602_byte_wr #(
        .EN_CYC        (EN_CYC),
        .BYTE_WAIT_CYC (BYTE_WAIT_CYC),
        .CLR_WAIT_CYC  (CLR_WAIT_CYC)
    ) u_byte_wr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_rs    (w_rs),
        .i_data  (w_data),
        .o_rs    (lcd_rs),
        .o_data  (lcd_data),
        .o_en    (lcd_en),
        .o_idle  (w_bw_idle),
        .o_done  (w_bw_done)
    );

    assign lcd_rw = 1'b0;
    assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lcd1602_digit_disp.sv
// tb_lcd1602_digit_disp
// Scoreboard bench: each stimulus pushes the {rs,data} bytes it should cause;
// a negedge monitor pops one entry per lcd_en rising edge and also checks the
// strobe width, the en-low gap between bytes and the final wait before idle.
module tb_lcd1602_digit_disp;

    localparam int PW  = 100;
    localparam int EN  = 4;
    localparam int BW  = 10;
    localparam int CW  = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit_in = 4'd2;
    logic       lcd_rs, lcd_rw, lcd_en, busy;
    logic [7:0] lcd_data;

    always #5 clk = ~clk;

    lcd1602_digit_disp #(
        .CLK_HZ        (50_000_000),
        .PWRUP_CYC     (PW),
        .EN_CYC        (EN),
        .BYTE_WAIT_CYC (BW),
        .CLR_WAIT_CYC  (CW),
        .DIGIT_ADDR    (7'h00)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .digit_in (digit_in),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .lcd_data (lcd_data),
        .busy     (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    logic [8:0] sb_q[$];

    task automatic push_update(input logic [3:0] d);
        sb_q.push_back(9'h080);
        sb_q.push_back({1'b1, (d < 4'd10) ? (8'h30 + {4'h0, d}) : 8'h2D});
    endtask

    task automatic push_init(input logic [3:0] d);
        sb_q.push_back(9'h038);
        sb_q.push_back(9'h00C);
        sb_q.push_back(9'h006);
        sb_q.push_back(9'h001);
        push_update(d);
    endtask

    // Monitor. En-low gap between strobes = wait + one handshake cycle +
    // the next byte's setup cycle; before IDLE only the wait is seen.
    bit         prev_en, prev_busy, have_fall;
    int         width, low, rises, wait_exp;
    logic [8:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en   = 1'b0;
            prev_busy = 1'b1;
            have_fall = 1'b0;
            width     = 0;
            low       = 0;
        end else begin
            if (!busy && prev_busy && have_fall) begin
                chk("idle_wait", low, wait_exp);
                have_fall = 1'b0;
            end
            if (lcd_en && !prev_en) begin
                rises++;
                if (have_fall) chk("byte_gap", low, wait_exp + 2);
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    chk("byte", {lcd_rs, lcd_data}, e);
                    wait_exp = (e == 9'h001) ? CW : BW;
                end
                width = 1;
            end else if (lcd_en) begin
                width++;
            end else if (prev_en) begin
                chk("en_width", width, EN);
                low       = 1;
                have_fall = 1'b1;
            end else begin
                low++;
            end
            prev_en   = lcd_en;
            prev_busy = busy;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin @(negedge clk); n++; end
        chk("idle_tmo", busy, 0);
    endtask

    // Two idle samples apart, so a one-cycle IDLE between back-to-back
    // updates is not mistaken for the end of activity.
    task automatic settle();
        wait_idle();
        repeat (8) @(negedge clk);
        wait_idle();
    endtask

    task automatic wait_byte(input logic [7:0] d);
        int n = 0;
        while (!(lcd_en && lcd_data == d) && n < 3000) begin @(negedge clk); n++; end
        chk("wait_byte", {31'b0, lcd_en && lcd_data == d}, 1);
    endtask

    initial begin
        int r0, n;
        repeat (3) @(negedge clk);
        chk("rst_en",   lcd_en,   0);
        chk("rst_rs",   lcd_rs,   0);
        chk("rst_rw",   lcd_rw,   0);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_busy", busy,     1);

        // Power-up and init with digit 2
        push_init(4'd2);
        rst_n = 1'b1;
        r0 = rises;
        repeat (PW) @(negedge clk);
        chk("pwrup_quiet", rises - r0, 0);
        settle();
        chk("sb_drain1", sb_q.size(), 0);

        // 2 -> 3 from IDLE: busy after 2 sync flops + 1 state cycle
        digit_in = 4'd3;
        push_update(4'd3);
        n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        chk("upd_lat", n, 3);

        // 3 -> 9 during the 0x80 byte, 9 -> 0 during the 0x39 byte
        wait_byte(8'h80);
        digit_in = 4'd9;
        push_update(4'd9);
        wait_byte(8'h39);
        digit_in = 4'd0;
        push_update(4'd0);
        settle();
        chk("sb_drain2", sb_q.size(), 0);

        // Out-of-range digit renders as dash, then holding it stays quiet
        digit_in = 4'd12;
        push_update(4'd12);
        settle();
        r0 = rises;
        repeat (300) @(negedge clk);
        chk("hold_quiet", rises - r0, 0);
        chk("sb_drain3", sb_q.size(), 0);

        // Reset while lcd_en is high clears the bus immediately
        digit_in = 4'd4;
        push_update(4'd4);
        wait_byte(8'h80);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_en",   lcd_en,   0);
        chk("midrst_rs",   lcd_rs,   0);
        chk("midrst_data", lcd_data, 8'h00);
        chk("midrst_busy", busy,     1);
        sb_q.delete();
        digit_in = 4'd7;
        repeat (3) @(negedge clk);
        push_init(4'd7);
        rst_n = 1'b1;
        r0 = rises;
        repeat (PW) @(negedge clk);
        chk("pwrup_quiet2", rises - r0, 0);
        settle();
        chk("sb_drain4", sb_q.size(), 0);
        chk("rw_low", lcd_rw, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd1602_digit_disp.md
LCD1602_DIGIT_DISP -- requirements
Module: lcd1602_digit_disp

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency.
REQ-002 Parameter PWRUP_CYC, default 1_000_000, power-up wait (20 ms).
REQ-003 Parameter EN_CYC, default 25, lcd_en high width (500 ns).
REQ-004 Parameter BYTE_WAIT_CYC, default 2_500, gap after each byte (50 us).
REQ-005 Parameter CLR_WAIT_CYC, default 100_000, gap after clear command (2 ms).
REQ-006 Parameter DIGIT_ADDR, default 7'h00, DDRAM address of the displayed digit.
REQ-007 Port clk, input, 1, system clock.
REQ-008 Port rst_n, input, 1, asynchronous active-low reset.
REQ-009 Port digit_in, input, 4, digit value from the button stage (0-9 nominal).
REQ-010 Port lcd_rs, output, 1, 0 = command, 1 = data.
REQ-011 Port lcd_rw, output, 1, tied 0 (write only).
REQ-012 Port lcd_en, output, 1, LCD enable strobe.
REQ-013 Port lcd_data, output, 8, LCD data bus.
REQ-014 Port busy, output, 1, high in every state except IDLE.

Function
REQ-015 FSM states: PWRUP, INIT, IDLE, SET_ADDR, WR_CHAR; each byte is issued through a byte-write cycle.
REQ-016 Byte-write cycle: lcd_rs/lcd_data stable 1 cycle, then lcd_en high exactly EN_CYC cycles, then lcd_en low with rs/data held for the wait period; total = 1 + EN_CYC + wait cycles.
REQ-017 Wait period is CLR_WAIT_CYC after command 0x01 and BYTE_WAIT_CYC after every other byte.
REQ-018 PWRUP: lcd_en low for PWRUP_CYC cycles after reset release, then INIT.
REQ-019 INIT sends in order: 0x38, 0x0C, 0x06, 0x01 (rs = 0), then SET_ADDR with a forced update.
REQ-020 SET_ADDR: capture digit_in into shown_digit, send 0x80 | DIGIT_ADDR (rs = 0), then WR_CHAR.
REQ-021 WR_CHAR: send 0x30 + shown_digit for 0-9 and 0x2D for 10-15 (rs = 1), then IDLE.
REQ-022 IDLE: when digit_in != shown_digit, go to SET_ADDR on the next cycle; otherwise stay.
REQ-023 digit_in is sampled only at SET_ADDR entry; a change during SET_ADDR/WR_CHAR triggers a new update after IDLE is reached.
REQ-024 digit_in passes through a 2-flop synchroniser before comparison and capture.
REQ-025 All wait counters are at least ceil(log2(max parameter + 1)) bits wide and saturate-free: they reload to 0 at every state or byte change.

Reset
REQ-026 Reset applies immediately, including mid-byte: lcd_en = 0, lcd_rs = 0, lcd_rw = 0, lcd_data = 8'h00, busy = 1, state = PWRUP, shown_digit = 4'h0, all counters 0.
REQ-027 After release, the full PWRUP and INIT sequence is repeated; no partial byte is resumed.

Structure
REQ-028 Shared package/include lcd1602_pkg holds state encodings, command constants (0x38, 0x0C, 0x06, 0x01, 0x80) and the ASCII offsets 0x30 and 0x2D.
REQ-029 One sub-module, lcd1602_byte_wr, implements REQ-016/017 with a start/done handshake: start is accepted only when idle; done pulses 1 cycle at the end of the wait.

Verification (bench uses small parameters: PWRUP_CYC = 100, EN_CYC = 4, BYTE_WAIT_CYC = 10, CLR_WAIT_CYC = 50)
REQ-030 Release reset with digit_in = 2 -> no lcd_en for 100 cycles; bytes 0x38, 0x0C, 0x06, 0x01, 0x80, 0x32 with rs = 0,0,0,0,0,1; busy falls after the 0x32 wait ends.
REQ-031 In IDLE, change digit_in 2->3 -> after 2 sync cycles plus 1, bytes 0x80 then 0x33; each lcd_en pulse is exactly 4 cycles; gap after 0x01 is 50 cycles, other gaps 10.
REQ-032 Change digit_in 3->9 during the 0x80 byte, then 9->0 during the 0x39 byte -> 0x39 is written, then a second update writes 0x30.
REQ-033 Drive digit_in = 12 -> 0x2D written; then digit_in = 12 held -> no further lcd_en activity.
REQ-034 Assert rst_n low while lcd_en is high -> lcd_en, lcd_rs and lcd_data clear in the same cycle; on release the full power-up and init sequence repeats.
